// File: rtl/led_port_arb.sv
// Four-requester LED port arbiter: round-robin grant with dwell slicing
// and a mandatory idle cycle between owners.
module led_port_arb #(
  parameter int         DWELL    = 16,
  parameter logic [7:0] IDLE_PAT = 8'h00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [7:0]  LPORT
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state, state_nx;
  logic [3:0] gnt_nx;
  logic [1:0] owner_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] win;
  logic [7:0] lport_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] win_dat, own_dat;
  logic       others;

  // first set bit scanned circularly from ptr
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end
  end

  assign win_dat = data[{win, 3'b000} +: 8];
  assign own_dat = data[{owner, 3'b000} +: 8];
  assign others  = |(req & ~gnt);
  assign busy    = (state == GRANT);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    owner_nx = owner;
    lport_nx = LPORT;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          gnt_nx   = 4'b0001 << win;
          owner_nx = win;
          lport_nx = win_dat;
          cnt_nx   = 8'd0;
          ptr_nx   = win + 2'd1;
        end
      end
      GRANT: begin
        if (!req[owner] || (cnt == LAST && others)) begin
          state_nx = IDLE;
          gnt_nx   = 4'b0000;
          owner_nx = 2'd0;
          lport_nx = IDLE_PAT;
          cnt_nx   = 8'd0;
        end else begin
          lport_nx = own_dat;
          if (cnt != LAST) cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      owner <= 2'd0;
      LPORT <= IDLE_PAT;
      cnt   <= 8'd0;
      ptr   <= 2'd0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      owner <= owner_nx;
      LPORT <= lport_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
    end
  end

endmodule
